ipif_link_ctrl_regs: RTL

// - Parametrised IPIF register decoder for NLINKS deserialiser links. Successor to the flat per-link parameter decoder.
// - Adds single-ack edge handshake, bad-select error reporting and self-clearing strobes.
// - Adds a per-link delay-load FSM that pulses delay_set and tracks delay_ready, with busy/done/timeout status.
// - Sits between the AXI-IPIF bridge and the per-link IDELAY/bit-align logic.

---
 rtl/ipif_link_ctrl_regs_if.sv | 24 ++
 rtl/ipif_link_ctrl_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipif_link_ctrl_regs_if.sv
// IPIF register-port bundle between the AXI-IPIF bridge and the link control register block.
// Ports: bus2ip_data/rdce/wrce driven by the bridge (master); ip2bus_data/rdack/wrack/error
// returned by the register block (slave). NCE = (NLINKS+1)*WORD_PER_LINK chip-enable lines.
interface ipif_link_ctrl_regs_if #(
  parameter int NCE = 52
);
  logic [31:0]    bus2ip_data;
  logic [NCE-1:0] bus2ip_rdce;
  logic [NCE-1:0] bus2ip_wrce;
  logic [31:0]    ip2bus_data;
  logic           ip2bus_rdack;
  logic           ip2bus_wrack;
  logic           ip2bus_error;

  modport master (
    output bus2ip_data, bus2ip_rdce, bus2ip_wrce,
    input  ip2bus_data, ip2bus_rdack, ip2bus_wrack, ip2bus_error
  );

  modport slave (
    input  bus2ip_data, bus2ip_rdce, bus2ip_wrce,
    output ip2bus_data, ip2bus_rdack, ip2bus_wrack, ip2bus_error
  );
endinterface

// File: rtl/ipif_link_ctrl_regs.sv
// IPIF register decoder for NLINKS deserialiser links with per-link delay-load FSMs.
// Latency: one ack pulse (with read data / error) one cycle after chip-enable rises from all-zero.
// Backpressure: none; a new access is only recognised after chip-enables return to zero.
//
// Ports: clk160, IPIF_bus2ip_resetn (sync, active-low), IPIF (slave modport of
// ipif_link_ctrl_regs_if), per-link delay_ready/bit_align_errors/delay_out/delay_out_N in,
// per-link delay_set/delay_mode/bypass_IOBUF/rstb_links/reset_counters/delay_in/
// delay_error_offset out, global_rstb_links and global_reset_counters out.
// Map: block 0 = global (word0 only), block j+1 = link j; word0 ctrl, word1 taps,
// word2 error-count snapshot, word3 status (RO). Unused words read 0, writes to them ignored.
// Optional macro IPIF_LOAD_TIMEOUT_EN: load FSM aborts WAIT after LOAD_TIMEOUT cycles.
module ipif_link_ctrl_regs #(
  parameter int NLINKS        = 12,
  parameter int WORD_PER_LINK = 4,
  parameter int DELAY_W       = 9,
  parameter int ERRCNT_W      = 16,
  parameter int LOAD_TIMEOUT  = 255
) (
  input  logic                               clk160,
  input  logic                               IPIF_bus2ip_resetn,
  ipif_link_ctrl_regs_if.slave               IPIF,
  input  logic [NLINKS-1:0]                  delay_ready,
  input  logic [NLINKS-1:0][ERRCNT_W-1:0]    bit_align_errors,
  input  logic [NLINKS-1:0][DELAY_W-1:0]     delay_out,
  input  logic [NLINKS-1:0][DELAY_W-1:0]     delay_out_N,
  output logic [NLINKS-1:0]                  delay_set,
  output logic [NLINKS-1:0]                  delay_mode,
  output logic [NLINKS-1:0]                  bypass_IOBUF,
  output logic [NLINKS-1:0]                  rstb_links,
  output logic [NLINKS-1:0]                  reset_counters,
  output logic [NLINKS-1:0][DELAY_W-1:0]     delay_in,
  output logic [NLINKS-1:0][DELAY_W-1:0]     delay_error_offset,
  output logic                               global_rstb_links,
  output logic                               global_reset_counters
);

  localparam int NCE    = (NLINKS + 1) * WORD_PER_LINK;
  localparam int LIDX_W = (NLINKS > 1) ? $clog2(NLINKS) : 1;

  if (WORD_PER_LINK < 4 || 2*DELAY_W + 4 > 32 || ERRCNT_W > 32 || LOAD_TIMEOUT < 1)
  begin : g_param_check
    $error("ipif_link_ctrl_regs: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} load_state_t;

  // ---------------------------------------------------------------- bus side
  logic [NCE-1:0] rdce, wrce, sel;
  logic [31:0]    wdata;
  logic           ce_d, ce_any, start, is_wr, sel_onehot, wr_go;
  int             blk, wrd;
  logic [LIDX_W-1:0] lnk;
  logic [31:0]    rd_val;
  logic           acc_err;
  logic [31:0]    rd_data_q;
  logic           rdack_q, wrack_q, err_q;
  logic           unused_wdata_bits;

  assign rdce  = IPIF.bus2ip_rdce;
  assign wrce  = IPIF.bus2ip_wrce;
  assign wdata = IPIF.bus2ip_data;
  assign unused_wdata_bits = ^wdata[31:2*DELAY_W];

  assign ce_any     = (|rdce) | (|wrce);
  assign start      = ce_any & ~ce_d;
  // A simultaneous read and write select is treated as a write.
  assign is_wr      = |wrce;
  assign sel        = is_wr ? wrce : rdce;
  assign sel_onehot = $onehot(sel);
  assign wr_go      = start & is_wr & sel_onehot;

  assign IPIF.ip2bus_data  = rd_data_q;
  assign IPIF.ip2bus_rdack = rdack_q;
  assign IPIF.ip2bus_wrack = wrack_q;
  assign IPIF.ip2bus_error = err_q;

  // ---------------------------------------------------------------- load FSM signals
  load_state_t state_q [NLINKS];
  load_state_t state_d [NLINKS];
  logic [NLINKS-1:0] load_req_q;
  logic [NLINKS-1:0] fsm_busy, link_busy, set_done;
  logic [NLINKS-1:0] done_q;
  logic [NLINKS-1:0] timeout_rd;

`ifdef IPIF_LOAD_TIMEOUT_EN
  localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);
  logic [TO_W-1:0]   wait_cnt_q [NLINKS];
  logic [NLINKS-1:0] wait_expired, set_timeout, timeout_q;
`endif

  // A load accepted on the bus but not yet seen by the FSM still counts as busy.
  assign link_busy = fsm_busy | load_req_q;

  // Locate the selected word; only meaningful when sel is one-hot, which also
  // bounds the index to the map by construction.
  always_comb begin
    blk = 0;
    wrd = 0;
    for (int b = 0; b <= NLINKS; b++) begin
      for (int w = 0; w < WORD_PER_LINK; w++) begin
        if (sel[b*WORD_PER_LINK + w]) begin
          blk = b;
          wrd = w;
        end
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    acc_err = ~sel_onehot;
    lnk     = '0;
    if (blk > 0) lnk = LIDX_W'(blk - 1);
    if (sel_onehot) begin
      if (blk == 0) begin
        if (wrd == 0) rd_val = {31'b0, global_rstb_links};
      end else begin
        case (wrd)
          0: rd_val = {28'b0, bypass_IOBUF[lnk], delay_mode[lnk], 1'b0, rstb_links[lnk]};
          1: rd_val = 32'({delay_error_offset[lnk], delay_in[lnk]});
          2: rd_val = 32'(bit_align_errors[lnk]);
          3: rd_val = 32'({timeout_rd[lnk], done_q[lnk], fsm_busy[lnk],
                           delay_out_N[lnk], delay_out[lnk], delay_ready[lnk]});
          default: rd_val = '0;
        endcase
        // Tap writes and load requests are refused while that link is loading.
        if (is_wr && link_busy[lnk] && (wrd == 1 || (wrd == 0 && wdata[4])))
          acc_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk160) begin
    if (!IPIF_bus2ip_resetn) begin
      ce_d                  <= 1'b0;
      rdack_q               <= 1'b0;
      wrack_q               <= 1'b0;
      err_q                 <= 1'b0;
      rd_data_q             <= '0;
      global_rstb_links     <= 1'b1;
      global_reset_counters <= 1'b0;
      rstb_links            <= '1;
      reset_counters        <= '0;
      delay_mode            <= '0;
      bypass_IOBUF          <= '0;
      delay_in              <= '0;
      delay_error_offset    <= '0;
      load_req_q            <= '0;
    end else begin
      ce_d      <= ce_any;
      rdack_q   <= start & ~is_wr;
      wrack_q   <= start & is_wr;
      err_q     <= start & acc_err;
      // Snapshot registers (e.g. error counters) are captured right here at access start.
      rd_data_q <= (start && !is_wr && sel_onehot) ? rd_val : '0;

      global_reset_counters <= 1'b0;
      reset_counters        <= '0;
      load_req_q            <= '0;

      if (wr_go && blk == 0 && wrd == 0) begin
        global_rstb_links     <= wdata[0];
        global_reset_counters <= wdata[1];
      end

      for (int j = 0; j < NLINKS; j++) begin
        if (wr_go && blk == j + 1) begin
          if (wrd == 0) begin
            rstb_links[j]     <= wdata[0];
            reset_counters[j] <= wdata[1];
            delay_mode[j]     <= wdata[2];
            bypass_IOBUF[j]   <= wdata[3];
            load_req_q[j]     <= wdata[4] & ~link_busy[j];
          end
          if (wrd == 1 && !link_busy[j]) begin
            delay_in[j]           <= wdata[DELAY_W-1:0];
            delay_error_offset[j] <= wdata[2*DELAY_W-1:DELAY_W];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk160) begin
    if (!IPIF_bus2ip_resetn) begin
      for (int j = 0; j < NLINKS; j++) state_q[j] <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NLINKS; j++) begin
      state_d[j] = state_q[j];
      case (state_q[j])
        S_IDLE:  if (load_req_q[j]) state_d[j] = S_PULSE;
        S_PULSE: state_d[j] = S_WAIT;
        S_WAIT: begin
          if (delay_ready[j]) state_d[j] = S_IDLE;
`ifdef IPIF_LOAD_TIMEOUT_EN
          else if (wait_expired[j]) state_d[j] = S_IDLE;
`endif
        end
        default: state_d[j] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < NLINKS; j++) begin
      delay_set[j] = (state_q[j] == S_PULSE);
      fsm_busy[j]  = (state_q[j] != S_IDLE);
      // delay_ready wins over an expiring counter in the same cycle.
      set_done[j]  = (state_q[j] == S_WAIT) && delay_ready[j];
`ifdef IPIF_LOAD_TIMEOUT_EN
      set_timeout[j] = (state_q[j] == S_WAIT) && !delay_ready[j] && wait_expired[j];
`endif
    end
  end

  // Sticky status; a new PULSE clears the outcome of the previous load.
  always_ff @(posedge clk160) begin
    if (!IPIF_bus2ip_resetn) begin
      done_q <= '0;
    end else begin
      for (int j = 0; j < NLINKS; j++) begin
        if (delay_set[j])      done_q[j] <= 1'b0;
        else if (set_done[j])  done_q[j] <= 1'b1;
      end
    end
  end

`ifdef IPIF_LOAD_TIMEOUT_EN
  // Counts cycles spent in WAIT; expiry after LOAD_TIMEOUT WAIT cycles.
  always_ff @(posedge clk160) begin
    if (!IPIF_bus2ip_resetn) begin
      for (int j = 0; j < NLINKS; j++) wait_cnt_q[j] <= '0;
      timeout_q <= '0;
    end else begin
      for (int j = 0; j < NLINKS; j++) begin
        wait_cnt_q[j] <= (state_q[j] == S_WAIT) ? wait_cnt_q[j] + TO_W'(1) : '0;
        if (delay_set[j])         timeout_q[j] <= 1'b0;
        else if (set_timeout[j])  timeout_q[j] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NLINKS; j++)
      wait_expired[j] = (wait_cnt_q[j] == TO_W'(LOAD_TIMEOUT - 1));
  end

  assign timeout_rd = timeout_q;
`else
  assign timeout_rd = '0;
`endif

endmodule
